id_operand_stage: RTL and testbench

- Parametrised operand-resolution and ID/EX pipeline register for the 16-bit core.
- Sits between the decode logic and EX. Takes up to two register read requests plus a decoded control bundle.
- Forwards results from NUM_FWD younger pipeline stages, with priority to the youngest. Interlocks on load-use hazards and inserts bubbles.
- Holds its outputs during downstream stalls, squashes on branch flush, and counts stall cycles.

---
 rtl/id_operand_stage.sv | 137 +++++++++++++
 tb/tb_id_operand_stage.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/id_operand_stage.sv
// ID/EX operand resolution and pipeline register: forwards from younger stages,
// interlocks on pending loads, holds on downstream stall, squashes on flush.
module id_operand_stage #(
    parameter int DW          = 16,
    parameter int RA_W        = 4,
    parameter int CTRL_W      = 16,
    parameter int NUM_FWD     = 2,
    parameter int ZERO_REG_EN = 0,
    parameter int STAT_W      = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    input  logic [CTRL_W-1:0]       in_ctrl,
    input  logic                    op0_re,
    input  logic [RA_W-1:0]         op0_addr,
    input  logic [DW-1:0]           op0_rf_data,
    input  logic [DW-1:0]           op0_alt,
    input  logic                    op1_re,
    input  logic [RA_W-1:0]         op1_addr,
    input  logic [DW-1:0]           op1_rf_data,
    input  logic [DW-1:0]           op1_alt,
    input  logic [NUM_FWD-1:0]      fwd_we,
    input  logic [NUM_FWD*RA_W-1:0] fwd_waddr,
    input  logic [NUM_FWD*DW-1:0]   fwd_wdata,
    input  logic [NUM_FWD-1:0]      fwd_pending,
    input  logic                    flush,
    input  logic                    ds_stall,
    output logic                    stall_req,
    output logic                    out_valid,
    output logic [CTRL_W-1:0]       out_ctrl,
    output logic [DW-1:0]           out_op0,
    output logic [DW-1:0]           out_op1,
    output logic [STAT_W-1:0]       stall_cnt
);

    typedef enum logic [1:0] {RUN, INTERLOCK, HOLD} state_t;

    state_t state, state_n;

    logic          op_re   [2];
    logic [RA_W-1:0] op_addr [2];
    logic [DW-1:0] op_rf   [2];
    logic [DW-1:0] op_alt  [2];
    logic [DW-1:0] op_val  [2];
    logic          op_haz  [2];

    logic hazard;
    logic load;
    logic bubble;
    logic inc;

    always_comb begin
        op_re[0]   = op0_re;
        op_addr[0] = op0_addr;
        op_rf[0]   = op0_rf_data;
        op_alt[0]  = op0_alt;
        op_re[1]   = op1_re;
        op_addr[1] = op1_addr;
        op_rf[1]   = op1_rf_data;
        op_alt[1]  = op1_alt;
    end

    // The first (youngest) matching source decides; older matches are masked by hit.
    always_comb begin
        logic hit;
        for (int unsigned k = 0; k < 2; k++) begin
            op_val[k] = op_rf[k];
            op_haz[k] = 1'b0;
            hit       = 1'b0;
            if (!op_re[k]) begin
                op_val[k] = op_alt[k];
            end else if (ZERO_REG_EN != 0 && op_addr[k] == '0) begin
                op_val[k] = '0;
            end else begin
                for (int unsigned i = 0; i < NUM_FWD; i++) begin
                    if (!hit && fwd_we[i] && fwd_waddr[i*RA_W +: RA_W] == op_addr[k]) begin
                        hit = 1'b1;
                        if (fwd_pending[i]) begin
                            op_haz[k] = 1'b1;
                        end else begin
                            op_val[k] = fwd_wdata[i*DW +: DW];
                        end
                    end
                end
            end
        end
    end

    assign hazard    = in_valid & (op_haz[0] | op_haz[1]);
    assign stall_req = ~rst & ~flush & (hazard | ds_stall);

    always_comb begin
        state_n = state;
        load    = 1'b0;
        bubble  = 1'b0;
        inc     = 1'b0;
        if (flush) begin
            bubble  = 1'b1;
            state_n = RUN;
        end else if (ds_stall) begin
            state_n = HOLD;
        end else if (hazard) begin
            bubble  = 1'b1;
            inc     = 1'b1;
            state_n = INTERLOCK;
        end else begin
            load    = 1'b1;
            state_n = RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RUN;
            out_valid <= 1'b0;
            out_ctrl  <= '0;
            out_op0   <= '0;
            out_op1   <= '0;
            stall_cnt <= '0;
        end else begin
            state <= state_n;
            if (load) begin
                out_valid <= in_valid;
                out_ctrl  <= in_ctrl;
                out_op0   <= op_val[0];
                out_op1   <= op_val[1];
            end else if (bubble) begin
                out_valid <= 1'b0;
            end
            if (inc && stall_cnt != '1) begin
                stall_cnt <= stall_cnt + STAT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_id_operand_stage.sv
// Bench for id_operand_stage: default config plus a ZERO_REG_EN=1 / STAT_W=2 instance on shared stimulus.
module tb_id_operand_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [15:0] in_ctrl;
    logic        op0_re, op1_re;
    logic [3:0]  op0_addr, op1_addr;
    logic [15:0] op0_rf_data, op1_rf_data, op0_alt, op1_alt;
    logic        src_we   [2];
    logic [3:0]  src_wa   [2];
    logic [15:0] src_wd   [2];
    logic        src_pend [2];
    logic        flush, ds_stall;

    logic [1:0]  fwd_we, fwd_pending;
    logic [7:0]  fwd_waddr;
    logic [31:0] fwd_wdata;

    assign fwd_we      = {src_we[1], src_we[0]};
    assign fwd_pending = {src_pend[1], src_pend[0]};
    assign fwd_waddr   = {src_wa[1], src_wa[0]};
    assign fwd_wdata   = {src_wd[1], src_wd[0]};

    logic        a_stall_req, a_valid, z_stall_req, z_valid;
    logic [15:0] a_ctrl, a_op0, a_op1, a_cnt, z_ctrl, z_op0, z_op1;
    logic [1:0]  z_cnt;

    always #5 clk = ~clk;

    id_operand_stage dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ctrl(in_ctrl),
        .op0_re(op0_re), .op0_addr(op0_addr), .op0_rf_data(op0_rf_data), .op0_alt(op0_alt),
        .op1_re(op1_re), .op1_addr(op1_addr), .op1_rf_data(op1_rf_data), .op1_alt(op1_alt),
        .fwd_we(fwd_we), .fwd_waddr(fwd_waddr), .fwd_wdata(fwd_wdata), .fwd_pending(fwd_pending),
        .flush(flush), .ds_stall(ds_stall), .stall_req(a_stall_req), .out_valid(a_valid),
        .out_ctrl(a_ctrl), .out_op0(a_op0), .out_op1(a_op1), .stall_cnt(a_cnt)
    );

    id_operand_stage #(.ZERO_REG_EN(1), .STAT_W(2)) dut_z (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ctrl(in_ctrl),
        .op0_re(op0_re), .op0_addr(op0_addr), .op0_rf_data(op0_rf_data), .op0_alt(op0_alt),
        .op1_re(op1_re), .op1_addr(op1_addr), .op1_rf_data(op1_rf_data), .op1_alt(op1_alt),
        .fwd_we(fwd_we), .fwd_waddr(fwd_waddr), .fwd_wdata(fwd_wdata), .fwd_pending(fwd_pending),
        .flush(flush), .ds_stall(ds_stall), .stall_req(z_stall_req), .out_valid(z_valid),
        .out_ctrl(z_ctrl), .out_op0(z_op0), .out_op1(z_op1), .stall_cnt(z_cnt)
    );

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Reference model: index 0 = default config, index 1 = zero-reg config with 2-bit counter.
    bit        m_valid [2];
    bit [15:0] m_ctrl  [2];
    bit [15:0] m_op0   [2];
    bit [15:0] m_op1   [2];
    int        m_cnt   [2];
    int        m_max   [2] = '{65535, 3};

    function automatic void operand(input bit zen, input logic re, input logic [3:0] addr,
                                    input logic [15:0] rf, input logic [15:0] alt,
                                    output logic [15:0] val, output bit haz);
        haz = 1'b0;
        val = rf;
        if (!re) begin
            val = alt;
            return;
        end
        if (zen && addr == 4'd0) begin
            val = 16'h0000;
            return;
        end
        for (int i = 0; i < 2; i++) begin
            if (src_we[i] && src_wa[i] == addr) begin
                if (src_pend[i]) haz = 1'b1;
                else             val = src_wd[i];
                return;
            end
        end
    endfunction

    function automatic bit model_hazard(input int c, output logic [15:0] v0, output logic [15:0] v1);
        bit h0, h1;
        operand(c == 1, op0_re, op0_addr, op0_rf_data, op0_alt, v0, h0);
        operand(c == 1, op1_re, op1_addr, op1_rf_data, op1_alt, v1, h1);
        return in_valid && (h0 || h1);
    endfunction

    always @(posedge clk) begin
        logic [15:0] v0, v1;
        bit h;
        for (int c = 0; c < 2; c++) begin
            h = model_hazard(c, v0, v1);
            if (rst) begin
                m_valid[c] = 1'b0; m_ctrl[c] = '0; m_op0[c] = '0; m_op1[c] = '0; m_cnt[c] = 0;
            end else if (flush) begin
                m_valid[c] = 1'b0;
            end else if (ds_stall) begin
                // outputs frozen
            end else if (h) begin
                m_valid[c] = 1'b0;
                if (m_cnt[c] < m_max[c]) m_cnt[c]++;
            end else begin
                m_valid[c] = in_valid; m_ctrl[c] = in_ctrl; m_op0[c] = v0; m_op1[c] = v1;
            end
        end
    end

    always @(negedge clk) begin
        logic [15:0] v0, v1;
        bit ha, hz;
        if (chk_en) begin
            ha = model_hazard(0, v0, v1);
            hz = model_hazard(1, v0, v1);
            check("a_stall_req", {31'd0, a_stall_req}, {31'd0, !rst && !flush && (ha || ds_stall)});
            check("z_stall_req", {31'd0, z_stall_req}, {31'd0, !rst && !flush && (hz || ds_stall)});
            check("a_valid", {31'd0, a_valid}, {31'd0, m_valid[0]});
            check("z_valid", {31'd0, z_valid}, {31'd0, m_valid[1]});
            check("a_ctrl", {16'd0, a_ctrl}, {16'd0, m_ctrl[0]});
            check("z_ctrl", {16'd0, z_ctrl}, {16'd0, m_ctrl[1]});
            check("a_op0", {16'd0, a_op0}, {16'd0, m_op0[0]});
            check("z_op0", {16'd0, z_op0}, {16'd0, m_op0[1]});
            check("a_op1", {16'd0, a_op1}, {16'd0, m_op1[0]});
            check("z_op1", {16'd0, z_op1}, {16'd0, m_op1[1]});
            check("a_cnt", {16'd0, a_cnt}, m_cnt[0]);
            check("z_cnt", {30'd0, z_cnt}, m_cnt[1]);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_src();
        for (int i = 0; i < 2; i++) begin
            src_we[i] = 1'b0; src_wa[i] = 4'd0; src_wd[i] = 16'h0000; src_pend[i] = 1'b0;
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_ctrl = 16'h0000;
        op0_re = 1'b0; op0_addr = 4'd0; op0_rf_data = 16'h0000; op0_alt = 16'h0000;
        op1_re = 1'b0; op1_addr = 4'd0; op1_rf_data = 16'h0000; op1_alt = 16'h0000;
        flush = 1'b0; ds_stall = 1'b0;
        clear_src();
        tick(); tick();
        check("reset_valid", {31'd0, a_valid}, 32'd0);
        check("reset_op0", {16'd0, a_op0}, 32'd0);
        check("reset_cnt", {16'd0, a_cnt}, 32'd0);
        check("reset_stall_req", {31'd0, a_stall_req}, 32'd0);
        rst = 1'b0;
        chk_en = 1'b1;

        // 1: plain register read plus immediate
        in_valid = 1'b1; in_ctrl = 16'h0101;
        op0_re = 1'b1; op0_addr = 4'd3; op0_rf_data = 16'h1111;
        op1_re = 1'b0; op1_alt = 16'h00FF;
        #1 check("t1_stall_req", {31'd0, a_stall_req}, 32'd0);
        tick();
        check("t1_valid", {31'd0, a_valid}, 32'd1);
        check("t1_op0", {16'd0, a_op0}, 32'h1111);
        check("t1_op1", {16'd0, a_op1}, 32'h00FF);
        check("t1_ctrl", {16'd0, a_ctrl}, 32'h0101);

        // 2: youngest source wins, then older one alone
        src_we[0] = 1'b1; src_wa[0] = 4'd5; src_wd[0] = 16'hAAAA;
        src_we[1] = 1'b1; src_wa[1] = 4'd5; src_wd[1] = 16'hBBBB;
        op0_addr = 4'd5;
        tick();
        check("t2_op0_young", {16'd0, a_op0}, 32'hAAAA);
        src_we[0] = 1'b0;
        tick();
        check("t2_op0_old", {16'd0, a_op0}, 32'hBBBB);

        // 3: load-use on op1 for one cycle, then forwarded from slot 1
        clear_src();
        op0_re = 1'b0; op0_alt = 16'h0042;
        op1_re = 1'b1; op1_addr = 4'd2; op1_rf_data = 16'hDEAD;
        src_we[0] = 1'b1; src_wa[0] = 4'd2; src_pend[0] = 1'b1;
        #1 check("t3_stall_req", {31'd0, a_stall_req}, 32'd1);
        tick();
        check("t3_bubble", {31'd0, a_valid}, 32'd0);
        clear_src();
        src_we[1] = 1'b1; src_wa[1] = 4'd2; src_wd[1] = 16'h1234;
        #1 check("t3_release", {31'd0, a_stall_req}, 32'd0);
        tick();
        check("t3_valid", {31'd0, a_valid}, 32'd1);
        check("t3_op1", {16'd0, a_op1}, 32'h1234);
        check("t3_cnt", {16'd0, a_cnt}, 32'd1);

        // 4: flush overrides an active hazard
        clear_src();
        src_we[0] = 1'b1; src_wa[0] = 4'd2; src_pend[0] = 1'b1;
        flush = 1'b1;
        #1 check("t4_stall_req", {31'd0, a_stall_req}, 32'd0);
        tick();
        check("t4_bubble", {31'd0, a_valid}, 32'd0);
        check("t4_cnt", {16'd0, a_cnt}, 32'd1);
        flush = 1'b0; clear_src();
        op1_re = 1'b0; op1_alt = 16'h4444; in_ctrl = 16'h0404;
        tick();
        check("t4_valid", {31'd0, a_valid}, 32'd1);
        check("t4_op1", {16'd0, a_op1}, 32'h4444);

        // 5: three-cycle downstream stall, then capture on release
        ds_stall = 1'b1; op1_alt = 16'h5555; in_ctrl = 16'h0505;
        for (int i = 0; i < 3; i++) begin
            #1 check("t5_stall_req", {31'd0, a_stall_req}, 32'd1);
            tick();
            check("t5_hold_op1", {16'd0, a_op1}, 32'h4444);
            check("t5_hold_ctrl", {16'd0, a_ctrl}, 32'h0404);
        end
        ds_stall = 1'b0;
        tick();
        check("t5_op1", {16'd0, a_op1}, 32'h5555);

        // 6: register 0 never stalls with ZERO_REG_EN, then counter saturation
        op0_re = 1'b1; op0_addr = 4'd0; op0_rf_data = 16'h7777;
        src_we[0] = 1'b1; src_wa[0] = 4'd0; src_pend[0] = 1'b1;
        #1 check("t6_z_stall_req", {31'd0, z_stall_req}, 32'd0);
        check("t6_a_stall_req", {31'd0, a_stall_req}, 32'd1);
        tick();
        check("t6_z_op0", {16'd0, z_op0}, 32'h0000);
        check("t6_z_valid", {31'd0, z_valid}, 32'd1);
        op0_addr = 4'd6;
        src_wa[0] = 4'd6;
        src_we[1] = 1'b1; src_wa[1] = 4'd6; src_wd[1] = 16'h6666;
        for (int i = 0; i < 5; i++) tick();
        check("t6_z_sat", {30'd0, z_cnt}, 32'd3);
        check("t6_a_cnt", {16'd0, a_cnt}, 32'd7);
        clear_src();
        tick();
        check("t6_op0_rf", {16'd0, a_op0}, 32'h7777);

        rst = 1'b1;
        tick();
        check("final_reset_cnt", {16'd0, a_cnt}, 32'd0);
        check("final_reset_ctrl", {16'd0, a_ctrl}, 32'd0);
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
